bcd_2_bin: RTL and testbench
============================

// Module: bcd_2_bin
// PURPOSE
//  Sequential packed-BCD to unsigned-binary converter (reverse double dabble: shift right, subtract 3).
//  Converts operator-entered decimal digits (switch/keypad BCD) to binary for the arithmetic datapath.
//  Valid/ready handshake on input and output. One bit is retired per clock.
// PARAMETERS
//  DIGITS  3   number of BCD digits on bcd_in (4 bits each, most significant digit in the top nibble)
//  BIN_W   10  output width; must equal ceil(log2(10**DIGITS)) (10 for 3 digits, 7 for 2 digits)
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst        in   1         synchronous, active-high reset
//  bcd_in     in   4*DIGITS  packed BCD operand
//  in_valid   in   1         bcd_in is valid
//  in_ready   out  1         block accepts an operand (high only in IDLE)
//  bin_out    out  BIN_W     binary result, stable while out_valid is high
//  out_valid  out  1         result available
//  out_ready  in   1         consumer takes the result
//  err        out  1         an input nibble was greater than 9 (only with BCD_CHECK_EN), qualified by out_valid
// BEHAVIOUR
//  Reset (rst high at an edge): state=IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, shift count=0.
//   Any in-flight conversion is dropped. Reset wins over every other event.
//  Working register sr = {bcd[4*DIGITS-1:0], bin[BIN_W-1:0]}.
//  States:
//   IDLE: in_ready=1. On in_valid&&in_ready: sr <= {bcd_in, 0}, cnt <= 0, go to SHIFT.
//   SHIFT: in_ready=0. Each edge:
//    - logical right shift of sr by 1 (bcd LSB moves to bin MSB; 0 enters bcd MSB);
//    - each BCD nibble of the shifted value that is >= 8 is reduced by 3, all nibbles in the same cycle;
//    - cnt++.
//    On the edge with cnt==BIN_W-1: bin_out <= shifted bin field, out_valid <= 1, go to DONE.
//   DONE: out_valid=1, bin_out/err held. On out_ready: out_valid <= 0, go to IDLE.
//    There is no same-cycle re-accept; in_ready rises the cycle after the output handshake.
//  Latency: out_valid is high exactly BIN_W cycles after the accepting edge.
//   Throughput: one operand per BIN_W+2 cycles when out_ready is tied high.
//  Arithmetic: bin_out = sum(d_i * 10**i); maximum value 10**DIGITS-1 fits BIN_W bits.
//   The BCD field is all zero after the last shift.
//  in_valid during SHIFT or DONE is ignored and bcd_in is not sampled. out_ready outside DONE is ignored.
//  Counter cnt is $clog2(BIN_W+1) bits and never wraps: it is bounded by the exit at BIN_W-1.
// CONFIGURATION
//  BCD_CHECK_EN defined:
//   - in IDLE on accept, if any nibble of bcd_in > 9, skip SHIFT: next edge bin_out=0, err=1, go to DONE
//     (latency 1);
//   - valid operands set err=0.
//  BCD_CHECK_EN undefined:
//   - err tied 0, no check logic;
//   - invalid nibbles are converted by the same algorithm with a deterministic but unspecified result.
// STRUCTURE
//  Shared package bcd_pkg:
//   - state encoding localparams ST_IDLE/ST_SHIFT/ST_DONE;
//   - BCD_DIGIT_MAX=9, BCD_ADJ_THRESH=8, BCD_ADJ=3;
//   - function bin_width(digits) returning ceil(log2(10**digits)).
//  Sub-module bcd_digit_adj: 4-bit combinational in->out, subtracts 3 when in >= 8. Instantiated DIGITS
//   times in a generate loop. It is the exact inverse of the add-3 cell used in binary-to-BCD.
//  Top level holds the FSM, cnt, sr, and the output registers.
// TESTING  (DIGITS=3, BIN_W=10)
//  bcd_in=12'h999, out_ready=1 -> out_valid high 10 cycles after accept, bin_out=10'd999, err=0.
//  bcd_in=12'h000 then 12'h255 back to back -> 0 then 255.
//   in_ready low throughout SHIFT/DONE; the second operand is accepted only after the first output
//   handshake.
//  12'h407 with out_ready low for 6 cycles -> out_valid and bin_out=407 held steady.
//   in_valid pulses with bcd_in=12'h111 during that time are not accepted.
//  rst asserted on the 4th SHIFT cycle of 12'h999 -> next cycle IDLE, in_ready=1, out_valid=0, bin_out=0.
//   A following 12'h123 gives 123.
//  BCD_CHECK_EN, bcd_in=12'h1A3 -> out_valid one cycle after accept, err=1, bin_out=0.
//   Without the macro: err stays 0 and out_valid appears after 10 cycles.
//  Exhaustive sweep 000..999 with random out_ready stalls -> bin_out equals the decimal value in every case.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// The optional nibble check is enabled by defining BCD_CHECK_EN.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    // Smallest width that holds 10**digits - 1, i.e. ceil(log2(10**digits)).
    function automatic int unsigned bin_width(input int unsigned digits);
        longint unsigned p;
        int unsigned     w;
        p = 1;
        for (int unsigned i = 0; i < digits; i++)
            p = p * 10;
        w = 0;
        while ((64'd1 << w) < p)
            w++;
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell: subtracts 3 when the nibble is 8 or more.
// Inverse of the add-3 cell used in binary-to-BCD conversion.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d >= BCD_ADJ_THRESH)
            q = d - BCD_ADJ;
    end

endmodule

// File: rtl/bcd_2_bin.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one bit per clock).
// Define BCD_CHECK_EN to flag operands containing a nibble above 9 via err.
module bcd_2_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = bin_width(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state_q;
    state_t             state_d;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_shift;
    logic [SR_W-1:0]    sr_next;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   bin_q;
    logic               accept;
    logic               last;

    assign accept   = (state_q == ST_IDLE) && in_valid;
    assign last     = (cnt == CNT_LAST);
    assign sr_shift = sr >> 1;

    // All digits are corrected in the same cycle, after the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (sr_shift[BIN_W + 4*g +: 4]),
            .q (bcd_adj[4*g +: 4])
        );
    end

    assign sr_next = {bcd_adj, sr_shift[BIN_W-1:0]};

`ifdef BCD_CHECK_EN
    logic bad;
    logic err_q;

    always_comb begin
        bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++)
            if (bcd_in[4*i +: 4] > BCD_DIGIT_MAX)
                bad = 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef BCD_CHECK_EN
                    state_d = bad ? ST_DONE : ST_SHIFT;
`else
                    state_d = ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: if (last)      state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            bin_q <= '0;
`ifdef BCD_CHECK_EN
            err_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                sr  <= {bcd_in, {BIN_W{1'b0}}};
                cnt <= '0;
`ifdef BCD_CHECK_EN
                err_q <= bad;
                if (bad)
                    bin_q <= '0;
`endif
            end else if (state_q == ST_SHIFT) begin
                sr  <= sr_next;
                cnt <= cnt + 1'b1;
                if (last)
                    bin_q <= sr_next[BIN_W-1:0];
            end
        end
    end

    assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_2_bin.sv
// Self-checking bench for bcd_2_bin (DIGITS=3, BIN_W=10): vector table, corner sequences, sweep.
module tb_bcd_2_bin;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [11:0]       bcd_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BIN_W-1:0]  bin_out;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              err;

    bcd_2_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        bit               care;
    } exp_t;

    typedef struct {
        logic [11:0]      bcd;
        logic [BIN_W-1:0] bin;
        int               stall;
        bit               poke;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   acc_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one operand, check latency and the held result, then complete the output handshake.
    task automatic send(input logic [11:0] bcd, input logic [BIN_W-1:0] exp_bin, input logic exp_err,
                        input bit care, input int exp_lat, input int stall, input bit poke);
        int   lat;
        bit   busy_ok;
        exp_t e;
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        bcd_in   = bcd;
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        bcd_in   = 12'hFFF;
        sb.push_back('{bin: exp_bin, err: exp_err, care: care});

        lat     = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("in_ready_low_while_busy", busy_ok, 1);

        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            if (poke) begin
                in_valid = (i % 2 == 0);
                bcd_in   = 12'h111;
            end
            @(posedge clk); #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            if (care) chk("stall_bin_out", bin_out, exp_bin);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            if (e.care) chk("bin_out", bin_out, e.bin);
            chk("err", err, e.err);
        end
        @(posedge clk); #1;
        chk("out_valid_after_handshake", out_valid, 0);
        chk("in_ready_after_handshake", in_ready, 1);
    endtask

    initial begin
        int prev;
        vecs[0] = '{bcd: 12'h999, bin: 10'd999, stall: 0, poke: 1'b0};
        vecs[1] = '{bcd: 12'h407, bin: 10'd407, stall: 6, poke: 1'b1};
        vecs[2] = '{bcd: 12'h001, bin: 10'd1,   stall: 0, poke: 1'b0};
        vecs[3] = '{bcd: 12'h010, bin: 10'd10,  stall: 1, poke: 1'b0};
        vecs[4] = '{bcd: 12'h100, bin: 10'd100, stall: 0, poke: 1'b0};
        vecs[5] = '{bcd: 12'h909, bin: 10'd909, stall: 3, poke: 1'b0};
        vecs[6] = '{bcd: 12'h090, bin: 10'd90,  stall: 0, poke: 1'b0};
        vecs[7] = '{bcd: 12'h555, bin: 10'd555, stall: 2, poke: 1'b1};
        vecs[8] = '{bcd: 12'h987, bin: 10'd987, stall: 0, poke: 1'b0};
        vecs[9] = '{bcd: 12'h512, bin: 10'd512, stall: 0, poke: 1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_bin_out", bin_out, 0);
        chk("reset_err", err, 0);

        for (int i = 0; i < 10; i++)
            send(vecs[i].bcd, vecs[i].bin, 1'b0, 1'b1, BIN_W, vecs[i].stall, vecs[i].poke);

        // Back to back with out_ready high: second accept BIN_W+2 cycles after the first.
        send(12'h000, 10'd0, 1'b0, 1'b1, BIN_W, 0, 1'b0);
        prev = acc_cyc;
        send(12'h255, 10'd255, 1'b0, 1'b1, BIN_W, 0, 1'b0);
        chk("throughput", acc_cyc - prev, BIN_W + 2);

        // Reset on the 4th SHIFT cycle drops the conversion.
        bcd_in   = 12'h999;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_bin_out", bin_out, 0);
        send(12'h123, 10'd123, 1'b0, 1'b1, BIN_W, 0, 1'b0);

`ifdef BCD_CHECK_EN
        send(12'h1A3, 10'd0, 1'b1, 1'b1, 1, 2, 1'b0);
        send(12'h321, 10'd321, 1'b0, 1'b1, BIN_W, 0, 1'b0);
`else
        send(12'h1A3, 10'd0, 1'b0, 1'b0, BIN_W, 0, 1'b0);
`endif

        for (int d = 0; d < 1000; d++) begin
            logic [11:0] b;
            b = {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
            send(b, 10'(d), 1'b0, 1'b1, BIN_W, $urandom_range(0, 3), 1'b0);
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
